riscv_dmem_arbiter: RTL and testbench

Shares one single-port data memory between two requesters: port 0 (CPU load/store path, after byte-lane alignment) and port 1 (DMA/debug). Round-robin or fixed-priority arbitration, one transaction in flight, registered memory-side request, and a read-timeout watchdog. Sits between the CPU's data-memory interface and the data memory.

---
 rtl/riscv_dmem_arbiter_if.sv | 37 +++
 rtl/riscv_dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port data memory.
// slave: arbiter view; master: requesters plus memory (bench / surrounding SoC).
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_dmem_arbiter_if;
  logic                  i_req0, i_we0, o_gnt0, o_rvalid0;
  logic [`XLEN-1:0]      i_addr0, i_wr_data0;
  logic [`XLEN/8-1:0]    i_byte_sel0;
  logic                  i_req1, i_we1, o_gnt1, o_rvalid1;
  logic [`XLEN-1:0]      i_addr1, i_wr_data1;
  logic [`XLEN/8-1:0]    i_byte_sel1;
  logic [`XLEN-1:0]      o_rd_data;
  logic                  o_timeout;
  logic                  o_mem_req, o_mem_we;
  logic [`XLEN-1:0]      o_mem_addr, o_mem_wr_data;
  logic [`XLEN/8-1:0]    o_mem_byte_sel;
  logic                  i_mem_ready, i_mem_rvalid;
  logic [`XLEN-1:0]      i_mem_rd_data;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wr_data0, i_byte_sel0,
    input  i_req1, i_we1, i_addr1, i_wr_data1, i_byte_sel1,
    input  i_mem_ready, i_mem_rvalid, i_mem_rd_data,
    output o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rd_data, o_timeout,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wr_data, o_mem_byte_sel
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wr_data0, i_byte_sel0,
    output i_req1, i_we1, i_addr1, i_wr_data1, i_byte_sel1,
    output i_mem_ready, i_mem_rvalid, i_mem_rd_data,
    input  o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rd_data, o_timeout,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wr_data, o_mem_byte_sel
  );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one transaction in flight,
// registered memory request, round-robin or CPU-priority selection, read-timeout watchdog.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_arbiter #(
  parameter int CPU_PRIORITY = 0,
  parameter int TIMEOUT      = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  riscv_dmem_arbiter_if.slave  bus
);
  localparam int XW = `XLEN;
  localparam int BW = `XLEN / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t          state_reg;
  logic            last_reg;
  logic            owner_reg;
  logic [CW-1:0]   cnt_reg;
  logic            mem_req_reg, mem_we_reg;
  logic [XW-1:0]   mem_addr_reg, mem_wr_data_reg, rd_data_reg;
  logic [BW-1:0]   mem_byte_sel_reg;
  logic [1:0]      rvalid_reg;
  logic            timeout_reg;

  logic [1:0]      req_vec, we_vec, gnt_vec;
  logic [XW-1:0]   addr_vec [2];
  logic [XW-1:0]   wdata_vec [2];
  logic [BW-1:0]   sel_vec [2];
  logic            win1;
  logic [CW:0]     cnt_inc;
  logic            timeout_hit;

  assign req_vec      = {bus.i_req1, bus.i_req0};
  assign we_vec       = {bus.i_we1, bus.i_we0};
  assign addr_vec[0]  = bus.i_addr0;
  assign addr_vec[1]  = bus.i_addr1;
  assign wdata_vec[0] = bus.i_wr_data0;
  assign wdata_vec[1] = bus.i_wr_data1;
  assign sel_vec[0]   = bus.i_byte_sel0;
  assign sel_vec[1]   = bus.i_byte_sel1;

  // Port 1 wins when alone, or under round-robin when port 0 had the last grant.
  assign win1 = req_vec[1] && (!req_vec[0] || ((CPU_PRIORITY == 0) && !last_reg));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt_vec[gi] = !i_rst && (state_reg == IDLE) && req_vec[gi] &&
                           (win1 == (gi == 1));
    end
  endgenerate

  assign cnt_inc     = {1'b0, cnt_reg} + (CW + 1)'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg        <= IDLE;
      last_reg         <= 1'b1;
      owner_reg        <= 1'b0;
      cnt_reg          <= '0;
      mem_req_reg      <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wr_data_reg  <= '0;
      mem_byte_sel_reg <= '0;
      rvalid_reg       <= '0;
      rd_data_reg      <= '0;
      timeout_reg      <= 1'b0;
    end else begin
      rvalid_reg  <= '0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            mem_req_reg      <= 1'b1;
            mem_we_reg       <= we_vec[win1];
            mem_addr_reg     <= addr_vec[win1];
            mem_wr_data_reg  <= wdata_vec[win1];
            mem_byte_sel_reg <= sel_vec[win1];
            owner_reg        <= win1;
            last_reg         <= win1;
            state_reg        <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.i_mem_ready) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= mem_we_reg ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (bus.i_mem_rvalid) begin
            rvalid_reg[owner_reg] <= 1'b1;
            rd_data_reg           <= bus.i_mem_rd_data;
            state_reg             <= IDLE;
          end else if (timeout_hit) begin
            rvalid_reg[owner_reg] <= 1'b1;
            rd_data_reg           <= '0;
            timeout_reg           <= 1'b1;
            state_reg             <= IDLE;
          end else begin
            cnt_reg <= cnt_inc[CW-1:0];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt0          = gnt_vec[0];
  assign bus.o_gnt1          = gnt_vec[1];
  assign bus.o_rvalid0       = rvalid_reg[0];
  assign bus.o_rvalid1       = rvalid_reg[1];
  assign bus.o_rd_data       = rd_data_reg;
  assign bus.o_timeout       = timeout_reg;
  assign bus.o_mem_req       = mem_req_reg;
  assign bus.o_mem_we        = mem_we_reg;
  assign bus.o_mem_addr      = mem_addr_reg;
  assign bus.o_mem_wr_data   = mem_wr_data_reg;
  assign bus.o_mem_byte_sel  = mem_byte_sel_reg;
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench: round-robin instance (rr) and CPU-priority instance (fp) share one stimulus.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_dmem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  riscv_dmem_arbiter_if bus_rr ();
  riscv_dmem_arbiter_if bus_fp ();

  riscv_dmem_arbiter #(.CPU_PRIORITY(0), .TIMEOUT(16)) dut_rr (
    .i_clk (clk), .i_rst (rst), .bus (bus_rr)
  );
  riscv_dmem_arbiter #(.CPU_PRIORITY(1), .TIMEOUT(16)) dut_fp (
    .i_clk (clk), .i_rst (rst), .bus (bus_fp)
  );

  // The priority instance sees exactly the same requester and memory stimulus.
  assign bus_fp.i_req0        = bus_rr.i_req0;
  assign bus_fp.i_we0         = bus_rr.i_we0;
  assign bus_fp.i_addr0       = bus_rr.i_addr0;
  assign bus_fp.i_wr_data0    = bus_rr.i_wr_data0;
  assign bus_fp.i_byte_sel0   = bus_rr.i_byte_sel0;
  assign bus_fp.i_req1        = bus_rr.i_req1;
  assign bus_fp.i_we1         = bus_rr.i_we1;
  assign bus_fp.i_addr1       = bus_rr.i_addr1;
  assign bus_fp.i_wr_data1    = bus_rr.i_wr_data1;
  assign bus_fp.i_byte_sel1   = bus_rr.i_byte_sel1;
  assign bus_fp.i_mem_ready   = bus_rr.i_mem_ready;
  assign bus_fp.i_mem_rvalid  = bus_rr.i_mem_rvalid;
  assign bus_fp.i_mem_rd_data = bus_rr.i_mem_rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [`XLEN-1:0] got, input logic [`XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
    $display("check %-14s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus_rr.i_req0 = 0; bus_rr.i_we0 = 0; bus_rr.i_addr0 = 0; bus_rr.i_wr_data0 = 0; bus_rr.i_byte_sel0 = 0;
    bus_rr.i_req1 = 0; bus_rr.i_we1 = 0; bus_rr.i_addr1 = 0; bus_rr.i_wr_data1 = 0; bus_rr.i_byte_sel1 = 0;
    bus_rr.i_mem_ready = 0; bus_rr.i_mem_rvalid = 0; bus_rr.i_mem_rd_data = 0;

    // Reset state; grants are masked while reset is held
    #3;
    bus_rr.i_req0 = 1;
    #1;
    chk("rst_gnt0", 32'(bus_rr.o_gnt0), 0);
    chk("rst_mem_req", 32'(bus_rr.o_mem_req), 0);
    chk("rst_rd_data", bus_rr.o_rd_data, 0);
    chk("rst_rvalid", 32'({bus_rr.o_rvalid0, bus_rr.o_rvalid1, bus_rr.o_timeout}), 0);
    bus_rr.i_req0 = 0;
    tick();
    #2 rst = 1'b0;
    tick();

    // Single zero-wait write from port 0
    bus_rr.i_req0 = 1; bus_rr.i_we0 = 1; bus_rr.i_addr0 = 32'h100;
    bus_rr.i_wr_data0 = 32'hDEADBEEF; bus_rr.i_byte_sel0 = 4'hF; bus_rr.i_mem_ready = 1;
    #1;
    chk("wr_gnt0", 32'(bus_rr.o_gnt0), 1);
    chk("wr_gnt1", 32'(bus_rr.o_gnt1), 0);
    tick();
    bus_rr.i_req0 = 0;
    chk("wr_mem_req", 32'(bus_rr.o_mem_req), 1);
    chk("wr_mem_we", 32'(bus_rr.o_mem_we), 1);
    chk("wr_mem_addr", bus_rr.o_mem_addr, 32'h100);
    chk("wr_mem_data", bus_rr.o_mem_wr_data, 32'hDEADBEEF);
    chk("wr_mem_sel", 32'(bus_rr.o_mem_byte_sel), 32'hF);
    tick();
    chk("wr_done_req", 32'(bus_rr.o_mem_req), 0);
    chk("wr_no_rvalid", 32'({bus_rr.o_rvalid0, bus_rr.o_rvalid1}), 0);

    // Port 1 read, memory ready after two wait cycles
    bus_rr.i_mem_ready = 0;
    bus_rr.i_req1 = 1; bus_rr.i_we1 = 0; bus_rr.i_addr1 = 32'h204; bus_rr.i_byte_sel1 = 4'hF;
    #1;
    chk("rd_gnt1", 32'(bus_rr.o_gnt1), 1);
    tick();
    bus_rr.i_req1 = 0;
    chk("rd_req_c1", 32'(bus_rr.o_mem_req), 1);
    chk("rd_mem_we", 32'(bus_rr.o_mem_we), 0);
    chk("rd_mem_addr", bus_rr.o_mem_addr, 32'h204);
    tick();
    chk("rd_req_c2", 32'(bus_rr.o_mem_req), 1);
    tick();
    bus_rr.i_mem_ready = 1;
    chk("rd_req_c3", 32'(bus_rr.o_mem_req), 1);
    tick();
    bus_rr.i_mem_ready = 0;
    chk("rd_req_drop", 32'(bus_rr.o_mem_req), 0);
    bus_rr.i_mem_rvalid = 1; bus_rr.i_mem_rd_data = 32'h12345678;
    tick();
    bus_rr.i_mem_rvalid = 0;
    chk("rd_rvalid1", 32'(bus_rr.o_rvalid1), 1);
    chk("rd_rvalid0", 32'(bus_rr.o_rvalid0), 0);
    chk("rd_data", bus_rr.o_rd_data, 32'h12345678);
    chk("rd_timeout", 32'(bus_rr.o_timeout), 0);
    tick();
    chk("rd_pulse_end", 32'(bus_rr.o_rvalid1), 0);
    chk("rd_data_hold", bus_rr.o_rd_data, 32'h12345678);

    // Continuous contention: rr alternates 0,1,0,1; fp always port 0
    bus_rr.i_mem_ready = 1;
    bus_rr.i_req0 = 1; bus_rr.i_we0 = 1; bus_rr.i_addr0 = 32'h10;
    bus_rr.i_req1 = 1; bus_rr.i_we1 = 1; bus_rr.i_addr1 = 32'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_gnt0_%0d", k), 32'(bus_rr.o_gnt0), 32'(k % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", k), 32'(bus_rr.o_gnt1), 32'(k % 2 == 1));
      chk($sformatf("fp_gnt0_%0d", k), 32'(bus_fp.o_gnt0), 1);
      chk($sformatf("fp_gnt1_%0d", k), 32'(bus_fp.o_gnt1), 0);
      tick();
      chk($sformatf("rr_addr_%0d", k), bus_rr.o_mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
    end
    bus_rr.i_req0 = 0;
    #1;
    chk("fp_gnt1_alone", 32'(bus_fp.o_gnt1), 1);
    chk("rr_gnt1_alone", 32'(bus_rr.o_gnt1), 1);
    tick();
    bus_rr.i_req1 = 0;
    tick();

    // Port 0 read with no memory response: watchdog fires after 16 WAIT_RD cycles
    bus_rr.i_req0 = 1; bus_rr.i_we0 = 0; bus_rr.i_addr0 = 32'h300;
    #1;
    chk("to_gnt0", 32'(bus_rr.o_gnt0), 1);
    tick();
    bus_rr.i_req0 = 0;
    tick();
    for (int k = 0; k < 16; k++) begin
      if (bus_rr.o_rvalid0 !== 1'b0 || bus_rr.o_timeout !== 1'b0)
        chk($sformatf("to_early_%0d", k), 32'({bus_rr.o_rvalid0, bus_rr.o_timeout}), 0);
      tick();
    end
    chk("to_rvalid0", 32'(bus_rr.o_rvalid0), 1);
    chk("to_flag", 32'(bus_rr.o_timeout), 1);
    chk("to_rd_data", bus_rr.o_rd_data, 0);
    chk("to_rvalid1", 32'(bus_rr.o_rvalid1), 0);
    bus_rr.i_mem_rvalid = 1; bus_rr.i_mem_rd_data = 32'hAAAA5555;
    tick();
    bus_rr.i_mem_rvalid = 0;
    chk("late_rvalid", 32'({bus_rr.o_rvalid0, bus_rr.o_rvalid1, bus_rr.o_timeout}), 0);
    chk("late_rd_data", bus_rr.o_rd_data, 0);

    // Reset while a port 0 read waits; last winner returns to port 1
    bus_rr.i_req0 = 1; bus_rr.i_we0 = 0; bus_rr.i_addr0 = 32'h400;
    tick();
    bus_rr.i_req0 = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus_rr.o_mem_req), 0);
    chk("mid_rst_addr", bus_rr.o_mem_addr, 0);
    chk("mid_rst_data", bus_rr.o_rd_data, 0);
    tick();
    rst = 1'b0;
    bus_rr.i_mem_rvalid = 1; bus_rr.i_mem_rd_data = 32'h55555555;
    tick();
    bus_rr.i_mem_rvalid = 0;
    chk("rst_no_rvalid", 32'({bus_rr.o_rvalid0, bus_rr.o_rvalid1}), 0);
    bus_rr.i_req0 = 1; bus_rr.i_we0 = 1; bus_rr.i_addr0 = 32'h10;
    bus_rr.i_req1 = 1; bus_rr.i_we1 = 1;
    #1;
    chk("post_rst_gnt0", 32'(bus_rr.o_gnt0), 1);
    chk("post_rst_gnt1", 32'(bus_rr.o_gnt1), 0);
    tick();
    bus_rr.i_req0 = 0; bus_rr.i_req1 = 0;
    tick();

    // Port 0 request withdrawn while port 1 write is stalled
    bus_rr.i_mem_ready = 0;
    bus_rr.i_req1 = 1; bus_rr.i_we1 = 1; bus_rr.i_addr1 = 32'h500;
    #1;
    chk("drop_gnt1", 32'(bus_rr.o_gnt1), 1);
    tick();
    bus_rr.i_req1 = 0;
    bus_rr.i_req0 = 1; bus_rr.i_we0 = 1; bus_rr.i_addr0 = 32'h600;
    #1;
    chk("drop_gnt0_a", 32'(bus_rr.o_gnt0), 0);
    tick();
    bus_rr.i_req0 = 0;
    bus_rr.i_mem_ready = 1;
    #1;
    chk("drop_gnt0_b", 32'(bus_rr.o_gnt0), 0);
    tick();
    chk("drop_req_off", 32'(bus_rr.o_mem_req), 0);
    chk("drop_gnt0_c", 32'(bus_rr.o_gnt0), 0);
    tick();
    chk("drop_no_access", 32'(bus_rr.o_mem_req), 0);
    chk("drop_addr_hold", bus_rr.o_mem_addr, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
